// File: rtl/uart_protocol_rx_pkg.sv
// Protocol constants and helpers for the framed UART link, used by both the
// transmit and receive sides.
package uart_protocol_rx_pkg;

   localparam logic [7:0] FRAME_HEADER     = 8'h80;
   localparam logic [7:0] FRAME_TAIL       = 8'h55;
   localparam int         FRAME_DATA_BYTES = 3;
   localparam logic [7:0] CRC8_POLY        = 8'h07;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_DATA,
      ST_CRC,
      ST_TAIL
   } rx_state_e;

   // Folds one byte into a running CRC8, MSB first, no reflection.
   function automatic logic [7:0] crc8Step(input logic [7:0] crc, input logic [7:0] data);
      logic [7:0] c;
      c = crc ^ data;
      for (int i = 0; i < 8; i++) begin
         if (c[7]) c = {c[6:0], 1'b0} ^ CRC8_POLY;
         else      c = {c[6:0], 1'b0};
      end
      return c;
   endfunction

endpackage

// File: rtl/uart_protocol_rx_crc8.sv
// Byte-wide CRC8 accumulator; a clear takes priority over folding in a byte.
module crc8
   import uart_protocol_rx_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       crc_en,
   input  logic       crc_clr,
   input  logic [7:0] data_in,
   output logic [7:0] crc_out
);

   logic [7:0] crc_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)       crc_q <= 8'h00;
      else if (crc_clr) crc_q <= 8'h00;
      else if (crc_en)  crc_q <= crc8Step(crc_q, data_in);
   end

   assign crc_out = crc_q;

endmodule

// File: rtl/uart_protocol_rx.sv
// Frame parser for 80 D1 D2 D3 CRC 55 packets arriving one byte per UART strobe,
// with an inter-byte timeout that drops partial frames.
module uart_protocol_rx
   import uart_protocol_rx_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 50000
) (
   input  logic       clk_50M,
   input  logic       rst_n,
   input  logic       uart_rx_done,
   input  logic [7:0] uart_rx_data,
   output logic [7:0] rev_data1,
   output logic [7:0] rev_data2,
   output logic [7:0] rev_data3,
   output logic       recv_done,
   output logic       crc_err,
   output logic       frame_err
);

   localparam int               CNT_W   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam int               IDX_W   = $clog2(FRAME_DATA_BYTES);
   localparam logic [IDX_W-1:0] IDX_END = IDX_W'(FRAME_DATA_BYTES - 1);

   rx_state_e        state_q, state_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic             crcBad_q, crcBad_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [7:0]       shadow_q [FRAME_DATA_BYTES];
   logic [7:0]       shadow_d [FRAME_DATA_BYTES];
   logic [7:0]       rev_q [FRAME_DATA_BYTES];
   logic [7:0]       rev_d [FRAME_DATA_BYTES];
   logic             recvDone_q, recvDone_d;
   logic             crcErr_q, crcErr_d;
   logic             frameErr_q, frameErr_d;
   logic             crcEn, crcClr, timeout;
   logic [7:0]       crcValue;

   crc8 u_crc8 (
      .clk     (clk_50M),
      .rst_n   (rst_n),
      .crc_en  (crcEn),
      .crc_clr (crcClr),
      .data_in (uart_rx_data),
      .crc_out (crcValue)
   );

   always_ff @(posedge clk_50M or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         idx_q      <= '0;
         crcBad_q   <= 1'b0;
         cnt_q      <= '0;
         shadow_q   <= '{default: 8'h00};
         rev_q      <= '{default: 8'h00};
         recvDone_q <= 1'b0;
         crcErr_q   <= 1'b0;
         frameErr_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         crcBad_q   <= crcBad_d;
         cnt_q      <= cnt_d;
         shadow_q   <= shadow_d;
         rev_q      <= rev_d;
         recvDone_q <= recvDone_d;
         crcErr_q   <= crcErr_d;
         frameErr_q <= frameErr_d;
      end
   end

   // A timeout wins over a coincident strobe; that byte is simply lost.
   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      crcBad_d   = crcBad_q;
      shadow_d   = shadow_q;
      rev_d      = rev_q;
      recvDone_d = 1'b0;
      crcErr_d   = 1'b0;
      frameErr_d = 1'b0;
      crcEn      = 1'b0;
      crcClr     = 1'b0;
      cnt_d      = (state_q == ST_IDLE || uart_rx_done) ? '0 : cnt_q + CNT_W'(1);
      timeout    = (state_q != ST_IDLE) && (cnt_q == TO_LAST);

      if (timeout) begin
         state_d    = ST_IDLE;
         frameErr_d = 1'b1;
         cnt_d      = '0;
      end else if (uart_rx_done) begin
         case (state_q)
            ST_IDLE: begin
               if (uart_rx_data == FRAME_HEADER) begin
                  crcClr   = 1'b1;
                  idx_d    = '0;
                  crcBad_d = 1'b0;
                  state_d  = ST_DATA;
               end
            end
            ST_DATA: begin
               shadow_d[idx_q] = uart_rx_data;
               crcEn           = 1'b1;
               if (idx_q == IDX_END) begin
                  idx_d   = '0;
                  state_d = ST_CRC;
               end else begin
                  idx_d = idx_q + IDX_W'(1);
               end
            end
            ST_CRC: begin
               if (uart_rx_data != crcValue) crcBad_d = 1'b1;
               state_d = ST_TAIL;
            end
            ST_TAIL: begin
               state_d = ST_IDLE;
               if (uart_rx_data != FRAME_TAIL) begin
                  frameErr_d = 1'b1;
               end else if (crcBad_q) begin
                  crcErr_d = 1'b1;
               end else begin
                  rev_d      = shadow_q;
                  recvDone_d = 1'b1;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   assign rev_data1 = rev_q[0];
   assign rev_data2 = rev_q[1];
   assign rev_data3 = rev_q[2];
   assign recv_done = recvDone_q;
   assign crc_err   = crcErr_q;
   assign frame_err = frameErr_q;

endmodule

// File: tb/tb_uart_protocol_rx.sv
// Directed bench for uart_protocol_rx: a byte-queue frame model is compared
// against the outputs every cycle, alongside literal expectations per scenario.
module tb_uart_protocol_rx;

   localparam int T = 40;

   logic       clk_50M      = 1'b0;
   logic       rst_n        = 1'b0;
   logic       uart_rx_done = 1'b0;
   logic [7:0] uart_rx_data = 8'h00;
   logic [7:0] rev_data1, rev_data2, rev_data3;
   logic       recv_done, crc_err, frame_err;

   int compared   = 0;
   int mismatched = 0;
   int cycle      = 0;
   int recvSeen   = 0;
   int crcSeen    = 0;
   int frameSeen  = 0;

   logic [7:0] frameQ [$];
   int         idleCount;
   logic       expRecv, expCrc, expFrame;
   logic [7:0] expRev [3];

   logic [7:0] goodFrame [6] = '{8'h80, 8'h01, 8'h02, 8'h03, 8'h48, 8'h55};
   logic [7:0] crcBadFrm [6] = '{8'h80, 8'h01, 8'h02, 8'h03, 8'h49, 8'h55};
   logic [7:0] tailBadFrm[6] = '{8'h80, 8'h01, 8'h02, 8'h03, 8'h48, 8'hAA};
   logic [7:0] oddFrame  [6];

   uart_protocol_rx #(.TIMEOUT_CYCLES(T)) dut (
      .clk_50M      (clk_50M),
      .rst_n        (rst_n),
      .uart_rx_done (uart_rx_done),
      .uart_rx_data (uart_rx_data),
      .rev_data1    (rev_data1),
      .rev_data2    (rev_data2),
      .rev_data3    (rev_data3),
      .recv_done    (recv_done),
      .crc_err      (crc_err),
      .frame_err    (frame_err)
   );

   always #5 clk_50M = ~clk_50M;

   // CRC8 as polynomial long division of the 24-bit payload by x^8+x^2+x+1.
   function automatic logic [7:0] crcOf(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
      logic [31:0] r;
      r = {a, b, c, 8'h00};
      for (int i = 31; i >= 8; i--)
         if (r[i]) r[i -: 9] = r[i -: 9] ^ 9'h107;
      return r[7:0];
   endfunction

   task automatic checkOutput(input string name, input logic [7:0] got, input logic [7:0] exp);
      compared++;
      if (got !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   task automatic applyStimulus(input logic [7:0] b, input int gap);
      @(negedge clk_50M);
      #1;
      uart_rx_done = 1'b1;
      uart_rx_data = b;
      if (gap > 0) begin
         @(negedge clk_50M);
         #1;
         uart_rx_done = 1'b0;
         repeat (gap - 1) @(negedge clk_50M);
      end
   endtask

   task automatic idleCycles(input int n);
      @(negedge clk_50M);
      #1;
      uart_rx_done = 1'b0;
      repeat (n) @(negedge clk_50M);
   endtask

   task automatic sendFrame(input logic [7:0] f [6], input int gap);
      for (int i = 0; i < 6; i++) applyStimulus(f[i], gap);
   endtask

   // Model step: a frame is a list of collected bytes, judged once six have arrived.
   task automatic modelStep();
      expRecv  = 1'b0;
      expCrc   = 1'b0;
      expFrame = 1'b0;
      if (!rst_n) begin
         frameQ.delete();
         idleCount = 0;
         expRev    = '{default: 8'h00};
      end else if (frameQ.size() > 0) begin
         if (idleCount == T - 1) begin
            expFrame = 1'b1;
            frameQ.delete();
            idleCount = 0;
         end else if (uart_rx_done) begin
            frameQ.push_back(uart_rx_data);
            idleCount = 0;
            if (frameQ.size() == 6) begin
               if (frameQ[5] != 8'h55) expFrame = 1'b1;
               else if (crcOf(frameQ[1], frameQ[2], frameQ[3]) != frameQ[4]) expCrc = 1'b1;
               else begin
                  expRecv = 1'b1;
                  expRev  = '{frameQ[1], frameQ[2], frameQ[3]};
               end
               frameQ.delete();
            end
         end else begin
            idleCount++;
         end
      end else if (uart_rx_done && uart_rx_data == 8'h80) begin
         frameQ.push_back(uart_rx_data);
         idleCount = 0;
      end
   endtask

   task automatic compareCycle();
      cycle++;
      recvSeen  += int'(recv_done);
      crcSeen   += int'(crc_err);
      frameSeen += int'(frame_err);
      checkOutput($sformatf("recv_done@%0d", cycle), {7'd0, recv_done}, {7'd0, expRecv});
      checkOutput($sformatf("crc_err@%0d", cycle), {7'd0, crc_err}, {7'd0, expCrc});
      checkOutput($sformatf("frame_err@%0d", cycle), {7'd0, frame_err}, {7'd0, expFrame});
      checkOutput($sformatf("rev_data1@%0d", cycle), rev_data1, expRev[0]);
      checkOutput($sformatf("rev_data2@%0d", cycle), rev_data2, expRev[1]);
      checkOutput($sformatf("rev_data3@%0d", cycle), rev_data3, expRev[2]);
   endtask

   initial begin
      int r0, c0, f0;
      expRecv   = 1'b0;
      expCrc    = 1'b0;
      expFrame  = 1'b0;
      expRev    = '{default: 8'h00};
      idleCount = 0;
      oddFrame  = '{8'h80, 8'hA5, 8'h80, 8'h55, crcOf(8'hA5, 8'h80, 8'h55), 8'h55};

      fork
         forever begin
            @(posedge clk_50M);
            modelStep();
         end
         forever begin
            @(negedge clk_50M);
            compareCycle();
         end
      join_none

      repeat (3) @(negedge clk_50M);
      checkOutput("reset rev_data1", rev_data1, 8'h00);
      checkOutput("reset recv_done", {7'd0, recv_done}, 8'h00);
      checkOutput("reset frame_err", {7'd0, frame_err}, 8'h00);
      #1 rst_n = 1'b1;

      $display("[TB] good frame");
      for (int i = 0; i < 5; i++) applyStimulus(goodFrame[i], 2);
      applyStimulus(8'h55, 1);
      checkOutput("recv_done after tail", {7'd0, recv_done}, 8'h01);
      idleCycles(3);
      checkOutput("good rev_data1", rev_data1, 8'h01);
      checkOutput("good rev_data2", rev_data2, 8'h02);
      checkOutput("good rev_data3", rev_data3, 8'h03);
      checkOutput("good recv count", 8'(recvSeen), 8'd1);

      $display("[TB] crc error frame");
      sendFrame(crcBadFrm, 2);
      idleCycles(3);
      checkOutput("crc err count", 8'(crcSeen), 8'd1);
      checkOutput("crc recv count", 8'(recvSeen), 8'd1);
      checkOutput("crc rev_data1 held", rev_data1, 8'h01);

      $display("[TB] bad tail then back-to-back good frame");
      sendFrame(tailBadFrm, 1);
      sendFrame(goodFrame, 0);
      sendFrame(goodFrame, 0);
      idleCycles(3);
      checkOutput("tail frame err count", 8'(frameSeen), 8'd1);
      checkOutput("tail crc err count", 8'(crcSeen), 8'd1);
      checkOutput("back-to-back recv count", 8'(recvSeen), 8'd3);

      $display("[TB] markers as payload");
      sendFrame(oddFrame, 1);
      idleCycles(3);
      checkOutput("odd rev_data1", rev_data1, 8'hA5);
      checkOutput("odd rev_data2", rev_data2, 8'h80);
      checkOutput("odd rev_data3", rev_data3, 8'h55);

      $display("[TB] inter-byte timeout");
      applyStimulus(8'h80, 1);
      applyStimulus(8'h01, 1);
      idleCycles(T + 5);
      checkOutput("timeout frame err count", 8'(frameSeen), 8'd2);
      sendFrame(goodFrame, 1);
      idleCycles(3);
      checkOutput("post-timeout recv count", 8'(recvSeen), 8'd5);
      checkOutput("post-timeout rev_data1", rev_data1, 8'h01);

      $display("[TB] strobe on timeout cycle");
      applyStimulus(8'h80, 1);
      repeat (T - 2) @(negedge clk_50M);
      sendFrame(goodFrame, 1);
      idleCycles(3);
      checkOutput("coincident frame err count", 8'(frameSeen), 8'd3);
      checkOutput("coincident recv count", 8'(recvSeen), 8'd5);

      $display("[TB] leading junk");
      applyStimulus(8'h12, 1);
      applyStimulus(8'h55, 1);
      sendFrame(goodFrame, 1);
      idleCycles(3);
      checkOutput("junk recv count", 8'(recvSeen), 8'd6);
      checkOutput("junk frame err count", 8'(frameSeen), 8'd3);

      $display("[TB] mid-frame reset");
      applyStimulus(8'h80, 1);
      applyStimulus(8'h01, 1);
      applyStimulus(8'h02, 1);
      #1 rst_n = 1'b0;
      repeat (2) @(negedge clk_50M);
      checkOutput("mid reset rev_data1", rev_data1, 8'h00);
      checkOutput("mid reset rev_data3", rev_data3, 8'h00);
      checkOutput("mid reset recv_done", {7'd0, recv_done}, 8'h00);
      #1 rst_n = 1'b1;
      r0 = recvSeen;
      c0 = crcSeen;
      f0 = frameSeen;
      applyStimulus(8'h03, 1);
      applyStimulus(8'h48, 1);
      applyStimulus(8'h55, 1);
      idleCycles(3);
      checkOutput("after reset recv pulses", 8'(recvSeen - r0), 8'd0);
      checkOutput("after reset crc pulses", 8'(crcSeen - c0), 8'd0);
      checkOutput("after reset frame pulses", 8'(frameSeen - f0), 8'd0);
      checkOutput("after reset rev_data2", rev_data2, 8'h00);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/uart_protocol_rx.md
UART_PROTOCOL_RX -- requirements
Module: uart_protocol_rx

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 50000, max clk_50M cycles between bytes of one frame (1 ms).
REQ-002 SHALL have port clk_50M  input  1  single system clock; all logic on its rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port uart_rx_done  input  1  one-cycle strobe, byte received by the UART byte receiver.
REQ-005 SHALL have port uart_rx_data  input  8  received byte, valid while uart_rx_done is high.
REQ-006 SHALL have ports rev_data1, rev_data2, rev_data3  output  8 each  payload of the last good frame.
REQ-007 SHALL have port recv_done  output  1  one-cycle pulse, good frame accepted.
REQ-008 SHALL have port crc_err  output  1  one-cycle pulse, frame complete but CRC mismatch.
REQ-009 SHALL have port frame_err  output  1  one-cycle pulse, bad tail or inter-byte timeout.

Function
REQ-010 SHALL parse frames of the form 0x80 (header), D1, D2, D3, CRC, 0x55 (tail), one byte per uart_rx_done.
REQ-011 SHALL implement states IDLE, DATA, CRC, TAIL, with the FSM advancing only on uart_rx_done (except timeout).
REQ-012 SHALL, in IDLE, discard any byte other than 0x80. On 0x80 it SHALL clear the CRC, clear the byte index and the crc_bad flag, and go to DATA.
REQ-013 SHALL, in DATA, store each byte into shadow register index 0..2 and fold it into the CRC, then go to CRC after the third byte.
REQ-014 SHALL treat 0x80 or 0x55 appearing in the DATA or CRC position as ordinary data, with no resynchronisation.
REQ-015 SHALL, in CRC, compare the byte to the running CRC8 (poly 0x07, init 0x00, MSB-first, no reflection, no final XOR over D1..D3), set crc_bad on mismatch, and go to TAIL.
REQ-016 SHALL, in TAIL, go to IDLE and:
- if byte == 0x55 and crc_bad is clear: copy shadows to rev_data1..3 and pulse recv_done on the next cycle;
- if byte == 0x55 and crc_bad is set: pulse crc_err only;
- if byte != 0x55: pulse frame_err only (regardless of crc_bad).
REQ-017 SHALL update rev_data1..3 only on a good frame and hold them otherwise.
REQ-018 SHALL keep recv_done, crc_err and frame_err mutually exclusive and exactly one cycle wide.
REQ-019 SHALL run an idle counter in states other than IDLE, cleared on every uart_rx_done. On reaching TIMEOUT_CYCLES-1 it SHALL return to IDLE and pulse frame_err; partial data SHALL be discarded.
REQ-020 SHALL give a uart_rx_done that coincides with the timeout cycle priority to the timeout, with the byte then evaluated in IDLE on the following strobe only.
REQ-021 SHALL accept back-to-back frames, with a header strobe allowed on the cycle after the tail.

Reset
REQ-022 SHALL, on rst_n low, asynchronously force state IDLE and zero the index, crc_bad, timeout counter, CRC, shadows, rev_data1..3, recv_done, crc_err and frame_err.
REQ-023 SHALL drop any partial frame on a mid-frame reset; after release it SHALL require a fresh 0x80.

Structure
REQ-024 SHALL place constants FRAME_HEADER=8'h80, FRAME_TAIL=8'h55, FRAME_DATA_BYTES=3 and CRC8_POLY=8'h07 in the shared protocol package used by the transmit side.
REQ-025 SHALL instantiate the existing crc8 sub-module (ports clk, rst_n, crc_en, crc_clr, data_in, crc_out) as its only sub-module.

Verification
REQ-026 SHALL cover: good frame 80 01 02 03 48 55 -> recv_done one cycle after the tail strobe; rev_data1..3 = 01,02,03.
REQ-027 SHALL cover: 80 01 02 03 49 55 -> crc_err pulse, no recv_done, rev_data unchanged.
REQ-028 SHALL cover: 80 01 02 03 48 AA -> frame_err pulse; then a good frame 80 01 02 03 48 55 -> recv_done.
REQ-029 SHALL cover: 80 01 followed by a gap of TIMEOUT_CYCLES -> frame_err, state IDLE; then a good frame -> recv_done.
REQ-030 SHALL cover: leading junk 12 55 80 01 02 03 48 55 -> junk ignored, single recv_done.
REQ-031 SHALL cover: rst_n pulsed low after 80 01 02 -> all outputs zero; a subsequent 03 48 55 produces no pulse.
